snake_unzip: RTL and testbench

SNAKE_UNZIP -- requirements
Module: snake_unzip

---
 rtl/snake_unzip_if.sv | 24 ++
 rtl/snake_unzip.sv | 87 ++++++++
 tb/tb_snake_unzip.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/snake_unzip_if.sv
// Stream-side and lane-side signals of the round-robin 1-to-4 splitter.
// The slave modport is the splitter, the master modport is its environment.
interface snake_unzip_if #(
    parameter int WIDTH = 8
);
    logic               in1_valid;
    logic [WIDTH-1:0]   in1;
    logic               in1_ready;
    logic [3:0]         out_valid;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_ready;
    logic [1:0]         lane_sel;
    logic [15:0]        beat_cnt;

    modport master (
        output in1_valid, in1, out_ready,
        input  in1_ready, out_valid, out_data, lane_sel, beat_cnt
    );

    modport slave (
        input  in1_valid, in1, out_ready,
        output in1_ready, out_valid, out_data, lane_sel, beat_cnt
    );
endinterface

// File: rtl/snake_unzip.sv
// Splits one input stream round-robin onto four lanes, each backed by a
// small FIFO. Lane order is strict: a full target lane stalls the input.
module snake_unzip #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    snake_unzip_if.slave  bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = DEPTH;
    localparam logic [AW:0] ONE_OCC  = 1;
    localparam logic [AW-1:0] ONE_PTR = 1;

    logic [1:0]         lane_sel_reg;
    logic [15:0]        beat_cnt_reg;
    logic               up_reg;
    logic [3:0]         full;
    logic [3:0]         push;
    logic [3:0]         pop;
    logic [3:0]         valid_vec;
    logic [4*WIDTH-1:0] data_vec;
    logic               accept;

    // Ready is derived only from registered state, so there is no path from out_ready.
    assign bus.in1_ready = up_reg & ~full[lane_sel_reg];
    assign accept        = bus.in1_valid & bus.in1_ready;
    assign bus.out_valid = valid_vec;
    assign bus.out_data  = data_vec;
    assign bus.lane_sel  = lane_sel_reg;
    assign bus.beat_cnt  = beat_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_reg       <= 1'b0;
            lane_sel_reg <= 2'd0;
            beat_cnt_reg <= 16'd0;
        end else begin
            up_reg <= 1'b1;
            if (accept) begin
                lane_sel_reg <= lane_sel_reg + 2'd1;
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [AW-1:0]    wr_ptr_reg;
            logic [AW-1:0]    rd_ptr_reg;
            logic [AW:0]      occ_reg;

            assign full[gi]      = (occ_reg == FULL_OCC);
            assign valid_vec[gi] = (occ_reg != '0);
            assign push[gi]      = accept & (lane_sel_reg == 2'(gi));
            assign pop[gi]       = valid_vec[gi] & bus.out_ready[gi];
            assign data_vec[gi*WIDTH +: WIDTH] = mem_reg[rd_ptr_reg];

            // Storage is cleared on reset so the lane heads read as zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        mem_reg[k] <= '0;
                    end
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                end else begin
                    if (push[gi]) begin
                        mem_reg[wr_ptr_reg] <= bus.in1;
                        wr_ptr_reg          <= wr_ptr_reg + ONE_PTR;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   occ_reg <= occ_reg + ONE_OCC;
                        2'b01:   occ_reg <= occ_reg - ONE_OCC;
                        default: occ_reg <= occ_reg;
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_snake_unzip.sv
// Directed and random checks of snake_unzip against a per-lane queue model
// where beat k lands in lane k mod 4 and each lane drains in order.
module tb_snake_unzip;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_unzip_if #(.WIDTH(WIDTH)) bus ();
    snake_unzip #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mq [4][$];
    int          m_sel = 0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_up  = 1'b0;
    int          popn [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_sel = 0;
        m_cnt = 16'd0;
        m_up  = 1'b0;
    endtask

    // One clock: drive inputs, compare all outputs with the model, step both.
    task automatic cycle(input bit v, input logic [7:0] d, input logic [3:0] ordy, output bit acc);
        bit       exp_rdy;
        bit [3:0] ev;
        bit [3:0] pp;
        bus.in1_valid = v;
        bus.in1       = d;
        bus.out_ready = ordy;
        exp_rdy = m_up && (mq[m_sel].size() < DEPTH);
        for (int i = 0; i < 4; i++) ev[i] = (mq[i].size() != 0);
        chk("in1_ready", 32'(bus.in1_ready), 32'(exp_rdy));
        chk("lane_sel", 32'(bus.lane_sel), 32'(m_sel));
        chk("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) chk($sformatf("lane%0d_head", i), 32'(bus.out_data[i*WIDTH +: WIDTH]), 32'(mq[i][0]));
        end
        acc = v && exp_rdy;
        pp  = ev & ordy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pp[i]) begin
                void'(mq[i].pop_front());
                popn[i]++;
            end
        end
        if (acc) begin
            mq[m_sel].push_back(d);
            m_sel = (m_sel + 1) % 4;
            m_cnt = m_cnt + 16'd1;
        end
        m_up = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] ordy);
        bit a;
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, ordy, a);
            n++;
        end while (!a && n < 50);
        if (!a) begin
            total++;
            bad++;
            $display("FAIL send_timeout observed=no_accept expected=accept data=%0h", d);
        end
    endtask

    task automatic idle(input int n, input logic [3:0] ordy);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, ordy, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in1_ready", 32'(bus.in1_ready), 32'h0);
        chk("rst_lane_sel", 32'(bus.lane_sel), 32'h0);
        chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit a;
        bus.in1_valid = 1'b0;
        bus.in1       = '0;
        bus.out_ready = 4'h0;
        for (int i = 0; i < 4; i++) popn[i] = 0;

        // Power-on reset
        @(posedge clk);
        #1;
        do_reset();

        // Eight beats with all consumers ready
        for (int k = 0; k < 8; k++) send(8'(8'h10 + k), 4'hF);
        chk("seq8_beat_cnt", 32'(bus.beat_cnt), 32'd8);
        chk("seq8_lane_sel", 32'(bus.lane_sel), 32'd0);
        idle(3, 4'hF);

        // All lanes blocked: eight fit, the ninth waits for lane 0
        for (int k = 0; k < 8; k++) send(8'(8'h20 + k), 4'h0);
        cycle(1'b1, 8'h28, 4'h0, a);
        chk("full_in1_ready", 32'(bus.in1_ready), 32'd0);
        chk("full_lane_sel", 32'(bus.lane_sel), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'hF);
        cycle(1'b1, 8'h28, 4'h1, a);
        chk("pop0_in1_ready", 32'(bus.in1_ready), 32'd1);
        cycle(1'b1, 8'h28, 4'h0, a);
        chk("ninth_beat_cnt", 32'(bus.beat_cnt), 32'd17);

        // Lane 2 blocked, the others drain, input stalls on lane 2
        for (int k = 0; k < 40; k++) cycle(1'b1, 8'($urandom), 4'b1011, a);
        chk("stall2_in1_ready", 32'(bus.in1_ready), 32'd0);
        chk("stall2_lane_sel", 32'(bus.lane_sel), 32'd2);
        chk("stall2_out_valid", 32'(bus.out_valid), 32'b0100);
        idle(6, 4'hF);
        chk("drain_out_valid", 32'(bus.out_valid), 32'h0);

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)), a);
        end
        idle(6, 4'hF);

        // Asynchronous reset with five beats buffered
        for (int k = 0; k < 5; k++) send(8'(8'h40 + k), 4'h0);
        chk("pre_rst_beats", 32'(mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()), 32'd5);
        do_reset();
        send(8'h55, 4'h0);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'b0001);
        chk("post_rst_lane_sel", 32'(bus.lane_sel), 32'd1);

        // Long stream across the beat counter wrap
        do_reset();
        for (int i = 0; i < 4; i++) popn[i] = 0;
        for (int k = 0; k < 65540; k++) send(8'(k), 4'hF);
        chk("wrap_beat_cnt", 32'(bus.beat_cnt), 32'd4);
        idle(4, 4'hF);
        for (int i = 0; i < 4; i++) chk($sformatf("wrap_lane%0d_count", i), 32'(popn[i]), 32'd16385);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
